// File: rtl/wb_stage_if.sv
// MEM-to-writeback bundle: MEM-stage result inputs and the regfile write port.
interface wb_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_we;
    logic [4:0]      in_rd_num;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_mem_data;
    logic            in_is_load;
    logic [1:0]      in_load_size;
    logic            in_load_unsigned;
    logic [1:0]      in_byte_off;
    logic [4:0]      rd_num;
    logic [XLEN-1:0] rd_data;
    logic            rd_we;

    modport master (
        output in_valid, in_we, in_rd_num, in_alu_result, in_mem_data,
               in_is_load, in_load_size, in_load_unsigned, in_byte_off,
        input  rd_num, rd_data, rd_we
    );

    modport slave (
        input  in_valid, in_we, in_rd_num, in_alu_result, in_mem_data,
               in_is_load, in_load_size, in_load_unsigned, in_byte_off,
        output rd_num, rd_data, rd_we
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: load extract/extend, regfile write port, halt-drain FSM, retire counter.
// Optional WB_BYPASS_EN adds combinational rs/rt forwarding from the registered write port.
module wb_stage #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_b,
    wb_stage_if.slave       bus,
    input  logic            halt_req,
    output logic            halted,
    output logic [31:0]     retire_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]      rs_num,
    input  logic [4:0]      rt_num,
    input  logic [XLEN-1:0] rs_raw,
    input  logic [XLEN-1:0] rt_raw,
    output logic [XLEN-1:0] rs_fwd,
    output logic [XLEN-1:0] rt_fwd
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [4:0]      rd_num_q;
    logic [XLEN-1:0] rd_data_q;
    logic            rd_we_q;
    logic [31:0]     retire_q;
    logic            accept;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;

    // Half loads pick the lane pair from offset bit 1 only; bit 0 is ignored.
    always_comb begin
        lane_byte = bus.in_mem_data[{bus.in_byte_off, 3'b000} +: 8];
        lane_half = bus.in_mem_data[{bus.in_byte_off[1], 4'b0000} +: 16];
        load_data = '0;
        case (bus.in_load_size)
            2'b00:   load_data = bus.in_load_unsigned ? {{(XLEN-8){1'b0}}, lane_byte}
                                                      : {{(XLEN-8){lane_byte[7]}}, lane_byte};
            2'b01:   load_data = bus.in_load_unsigned ? {{(XLEN-16){1'b0}}, lane_half}
                                                      : {{(XLEN-16){lane_half[15]}}, lane_half};
            default: load_data = bus.in_mem_data;
        endcase
        wb_data = bus.in_is_load ? load_data : bus.in_alu_result;
    end

    assign accept = bus.in_valid && (state != HALTED);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RUN: begin
                if (halt_req) begin
                    state_n = DRAIN;
                    cnt_n   = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (cnt == 4'd0) state_n = HALTED;
                else             cnt_n   = cnt - 4'd1;
            end
            HALTED:  state_n = HALTED;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= RUN;
            cnt       <= '0;
            rd_num_q  <= '0;
            rd_data_q <= '0;
            rd_we_q   <= 1'b0;
            retire_q  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rd_num_q  <= bus.in_rd_num;
            rd_data_q <= wb_data;
            rd_we_q   <= accept && bus.in_we && (bus.in_rd_num != 5'd0);
            if (accept) retire_q <= retire_q + 32'd1;
        end
    end

    assign bus.rd_num   = rd_num_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_we    = rd_we_q;
    assign halted       = (state == HALTED);
    assign retire_count = retire_q;

`ifdef WB_BYPASS_EN
    assign rs_fwd = (rd_we_q && (rd_num_q == rs_num)) ? rd_data_q : rs_raw;
    assign rt_fwd = (rd_we_q && (rd_num_q == rt_num)) ? rd_data_q : rt_raw;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/load writeback, rd=0, halt drain, async reset, bypass.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic [31:0] retire_count;
    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [31:0] exp_cnt;

    wb_stage_if #(.XLEN(32)) bus ();

`ifdef WB_BYPASS_EN
    logic [4:0]  rs_num = '0, rt_num = '0;
    logic [31:0] rs_raw = '0, rt_raw = '0;
    logic [31:0] rs_fwd, rt_fwd;
`endif

    wb_stage #(.XLEN(32), .DRAIN_CYCLES(3)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .bus          (bus),
        .halt_req     (halt_req),
        .halted       (halted),
        .retire_count (retire_count)
`ifdef WB_BYPASS_EN
        ,
        .rs_num       (rs_num),
        .rt_num       (rt_num),
        .rs_raw       (rs_raw),
        .rt_raw       (rt_raw),
        .rs_fwd       (rs_fwd),
        .rt_fwd       (rt_fwd)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [31:0] alu);
        bus.in_valid         = v;
        bus.in_we            = we;
        bus.in_rd_num        = rd;
        bus.in_alu_result    = alu;
        bus.in_is_load       = 1'b0;
        bus.in_mem_data      = '0;
        bus.in_load_size     = 2'b10;
        bus.in_load_unsigned = 1'b0;
        bus.in_byte_off      = 2'b00;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rst_b = 1'b0;
        step();
        total++; if (bus.rd_we !== 1'b0) $display("FAIL reset_rd_we: got %b expected 0", bus.rd_we); else passed++;
        total++; if (bus.rd_num !== 5'd0) $display("FAIL reset_rd_num: got %0d expected 0", bus.rd_num); else passed++;
        total++; if (bus.rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else passed++;
        total++; if (retire_count !== 32'd0) $display("FAIL reset_retire: got %0d expected 0", retire_count); else passed++;
        rst_b = 1'b1;
        exp_cnt = 32'd0;
        step();
    endtask

    task automatic test_alu_write();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        exp_cnt++;
        total++; if (bus.rd_we !== 1'b1) $display("FAIL alu_rd_we: got %b expected 1", bus.rd_we); else passed++;
        total++; if (bus.rd_num !== 5'd5) $display("FAIL alu_rd_num: got %0d expected 5", bus.rd_num); else passed++;
        total++; if (bus.rd_data !== 32'hDEADBEEF) $display("FAIL alu_rd_data: got %h expected deadbeef", bus.rd_data); else passed++;
        total++; if (retire_count !== 32'd1) $display("FAIL alu_retire: got %0d expected 1", retire_count); else passed++;
        drive(1'b0, 1'b1, 5'd5, 32'h0);
        step();
        total++; if (bus.rd_we !== 1'b0) $display("FAIL idle_rd_we: got %b expected 0", bus.rd_we); else passed++;
        total++; if (retire_count !== 32'd1) $display("FAIL idle_retire: got %0d expected 1", retire_count); else passed++;
    endtask

    task automatic test_loads();
        // size, unsigned, offset, expected (mem = 0x80FF7F01)
        logic [1:0]  sz  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11};
        logic        uns [8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        logic [1:0]  off [8] = '{2'd3,  2'd3,  2'd2,  2'd0,  2'd1,  2'd3,  2'd1,  2'd2};
        logic [31:0] exp [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                 32'h80FF7F01, 32'hFFFF80FF, 32'h0000007F, 32'h80FF7F01};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 5'(i + 10), 32'h0BAD0BAD);
            bus.in_is_load       = 1'b1;
            bus.in_mem_data      = 32'h80FF7F01;
            bus.in_load_size     = sz[i];
            bus.in_load_unsigned = uns[i];
            bus.in_byte_off      = off[i];
            step();
            exp_cnt++;
            total++; if (bus.rd_data !== exp[i]) $display("FAIL load_%0d_data: got %h expected %h", i, bus.rd_data, exp[i]); else passed++;
            total++; if (retire_count !== exp_cnt) $display("FAIL load_%0d_retire: got %0d expected %0d", i, retire_count, exp_cnt); else passed++;
        end
    endtask

    task automatic test_rd_zero();
        drive(1'b1, 1'b1, 5'd0, 32'h1234);
        step();
        exp_cnt++;
        total++; if (bus.rd_we !== 1'b0) $display("FAIL rd0_rd_we: got %b expected 0", bus.rd_we); else passed++;
        total++; if (retire_count !== exp_cnt) $display("FAIL rd0_retire: got %0d expected %0d", retire_count, exp_cnt); else passed++;
        drive(1'b1, 1'b0, 5'd3, 32'h5678);
        step();
        exp_cnt++;
        total++; if (bus.rd_we !== 1'b0) $display("FAIL nowe_rd_we: got %b expected 0", bus.rd_we); else passed++;
        total++; if (retire_count !== exp_cnt) $display("FAIL nowe_retire: got %0d expected %0d", retire_count, exp_cnt); else passed++;
    endtask

    task automatic test_halt_drain();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        total++; if (halted !== 1'b0) $display("FAIL drain_h0: got %b expected 0", halted); else passed++;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'(32'h100 + i));
            step();
            exp_cnt++;
            total++; if (bus.rd_we !== 1'b1) $display("FAIL drain_r%0d_we: got %b expected 1", i, bus.rd_we); else passed++;
            total++; if (bus.rd_data !== 32'(32'h100 + i)) $display("FAIL drain_r%0d_data: got %h expected %h", i, bus.rd_data, 32'(32'h100 + i)); else passed++;
            total++; if (halted !== (i == 3)) $display("FAIL drain_halted_%0d: got %b expected %b", i, halted, (i == 3)); else passed++;
        end
        total++; if (retire_count !== exp_cnt) $display("FAIL drain_retire: got %0d expected %0d", retire_count, exp_cnt); else passed++;
        halt_req = 1'b1;
        drive(1'b1, 1'b1, 5'd4, 32'h444);
        step();
        step();
        halt_req = 1'b0;
        total++; if (bus.rd_we !== 1'b0) $display("FAIL halted_rd_we: got %b expected 0", bus.rd_we); else passed++;
        total++; if (retire_count !== exp_cnt) $display("FAIL halted_retire: got %0d expected %0d", retire_count, exp_cnt); else passed++;
        total++; if (halted !== 1'b1) $display("FAIL halted_sticky: got %b expected 1", halted); else passed++;
    endtask

    task automatic test_async_reset();
        #2;
        rst_b = 1'b0;
        #1;
        total++; if (halted !== 1'b0) $display("FAIL arst_halted: got %b expected 0", halted); else passed++;
        total++; if (bus.rd_we !== 1'b0) $display("FAIL arst_rd_we: got %b expected 0", bus.rd_we); else passed++;
        total++; if (retire_count !== 32'd0) $display("FAIL arst_retire: got %0d expected 0", retire_count); else passed++;
        #1;
        rst_b = 1'b1;
        exp_cnt = 32'd0;
        drive(1'b1, 1'b1, 5'd6, 32'hCAFEF00D);
        step();
        exp_cnt++;
        total++; if (bus.rd_we !== 1'b1) $display("FAIL resume_rd_we: got %b expected 1", bus.rd_we); else passed++;
        total++; if (bus.rd_data !== 32'hCAFEF00D) $display("FAIL resume_rd_data: got %h expected cafef00d", bus.rd_data); else passed++;
        total++; if (retire_count !== exp_cnt) $display("FAIL resume_retire: got %0d expected %0d", retire_count, exp_cnt); else passed++;
    endtask

    task automatic test_halt_with_valid();
        drive(1'b1, 1'b1, 5'd9, 32'h99);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        exp_cnt++;
        total++; if (bus.rd_we !== 1'b1) $display("FAIL hv_rd_we: got %b expected 1", bus.rd_we); else passed++;
        total++; if (retire_count !== exp_cnt) $display("FAIL hv_retire: got %0d expected %0d", retire_count, exp_cnt); else passed++;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        total++; if (halted !== 1'b0) $display("FAIL hv_early: got %b expected 0", halted); else passed++;
        step();
        total++; if (halted !== 1'b1) $display("FAIL hv_halted: got %b expected 1", halted); else passed++;
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        rst_b = 1'b0;
        #1;
        rst_b = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 32'h55);
        step();
        rs_num = 5'd7; rs_raw = 32'h11; rt_num = 5'd0; rt_raw = 32'h22;
        #1;
        total++; if (rs_fwd !== 32'h55) $display("FAIL byp_rs: got %h expected 55", rs_fwd); else passed++;
        total++; if (rt_fwd !== 32'h22) $display("FAIL byp_rt: got %h expected 22", rt_fwd); else passed++;
        rs_num = 5'd8;
        #1;
        total++; if (rs_fwd !== 32'h11) $display("FAIL byp_rs_miss: got %h expected 11", rs_fwd); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_alu_write();
        test_loads();
        test_rd_zero();
        test_halt_drain();
        test_async_reset();
        test_halt_with_valid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
